// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit: FSM state enum,
// opcode constants and the encodings of the ALUOp / ALUSrcB / PCSource /
// exc_cause control fields.
// Optional feature macro: MULTICYCLE_JUMP_EN (adds the JUMP state).
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXEC,
    S_ALUWB,
    S_BRANCH,
`ifdef MULTICYCLE_JUMP_EN
    S_JUMP,
`endif
    S_ADDI_EX,
    S_ADDI_WB,
    S_TRAP
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_4     = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_SHIMM = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

endpackage

// File: rtl/ctrl_wait_timer.sv
// Memory wait timer. Counts cycles spent waiting for mem_ready while tick is
// high; expired fires on the cycle the count sits at MEM_TIMEOUT-1 and ready
// is still low (ready on that cycle wins).
// Ports: clk, rst (sync, active high), clear (zero the count), tick (a
//        waiting state is active), ready (memory done), expired (out).
module ctrl_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  input  logic ready,
  output logic expired
);

  localparam int W = $clog2(MEM_TIMEOUT);
  localparam logic [W-1:0] LAST = W'(MEM_TIMEOUT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)
      cnt_d = '0;
    else if (tick && !ready && cnt_q != LAST)
      cnt_d = cnt_q + 1'b1;
  end

  assign expired = tick && !ready && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM. Moore-decoded datapath controls (FETCH
// IRWrite/PCWrite gated by mem_ready), memory-wait timeout and illegal
// opcode traps, and a retired-instruction counter.
// Ports: clk, rst (sync, active high), opcode, mem_ready in; datapath
//        strobes/selects, exc_valid/exc_cause, instr_count out.
// Optional feature macro: MULTICYCLE_JUMP_EN (j instruction support; when
// undefined opcode 000010 traps as illegal).
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             Branch,
  output logic             BranchNe,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic             exc_valid,
  output logic [1:0]       exc_cause,
  output logic [CNT_W-1:0] instr_count
);

  state_e           state_q, state_d, st;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             tick, expired, retire;

  // Only the memory-wait states run the timer. Any state change clears it,
  // which covers every entry into FETCH/MEMRD/MEMWR.
  assign tick = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);

  ctrl_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_d != state_q),
    .tick   (tick),
    .ready  (mem_ready),
    .expired(expired)
  );

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (mem_ready)    state_d = S_DECODE;
        else if (expired) begin state_d = S_TRAP; cause_d = CAUSE_TIMEOUT; end
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:      state_d = S_EXEC;
          OP_LW, OP_SW:  state_d = S_MEMADR;
          OP_BEQ,OP_BNE: state_d = S_BRANCH;
          OP_ADDI:       state_d = S_ADDI_EX;
`ifdef MULTICYCLE_JUMP_EN
          OP_J:          state_d = S_JUMP;
`endif
          default: begin state_d = S_TRAP; cause_d = CAUSE_ILLEGAL; end
        endcase
      end
      // opcode is held stable until retirement, so it still selects lw/sw here
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        if (mem_ready)    state_d = S_MEMWB;
        else if (expired) begin state_d = S_TRAP; cause_d = CAUSE_TIMEOUT; end
      end
      S_MEMWR: begin
        if (mem_ready)    begin state_d = S_FETCH; retire = 1'b1; end
        else if (expired) begin state_d = S_TRAP; cause_d = CAUSE_TIMEOUT; end
      end
      S_MEMWB:   begin state_d = S_FETCH; retire = 1'b1; end
      S_EXEC:    state_d = S_ALUWB;
      S_ALUWB:   begin state_d = S_FETCH; retire = 1'b1; end
      S_BRANCH:  begin state_d = S_FETCH; retire = 1'b1; end
`ifdef MULTICYCLE_JUMP_EN
      S_JUMP:    begin state_d = S_FETCH; retire = 1'b1; end
`endif
      S_ADDI_EX: state_d = S_ADDI_WB;
      S_ADDI_WB: begin state_d = S_FETCH; retire = 1'b1; end
      S_TRAP:    state_d = S_FETCH;
      default:   state_d = S_FETCH;
    endcase
    count_d = count_q + CNT_W'(retire);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cause_q <= CAUSE_NONE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      count_q <= count_d;
    end
  end

  assign instr_count = count_q;

  // While rst is high the outputs already show FETCH values with no write
  // strobes, independent of whatever state is being reset out of.
  assign st = rst ? S_FETCH : state_q;

  always_comb begin
    PCWrite   = 1'b0;
    Branch    = 1'b0;
    BranchNe  = 1'b0;
    IorD      = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    MemtoReg  = 1'b0;
    IRWrite   = 1'b0;
    RegDst    = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = SRCB_B;
    ALUOp     = ALUOP_ADD;
    PCSource  = PCSRC_ALU;
    exc_valid = 1'b0;
    exc_cause = CAUSE_NONE;
    case (st)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_4;
        IRWrite = mem_ready & ~rst;
        PCWrite = mem_ready & ~rst;
      end
      S_DECODE:  ALUSrcB = SRCB_SHIMM;
      S_MEMADR:  begin ALUSrcA = 1'b1; ALUSrcB = SRCB_IMM; end
      S_MEMRD:   begin IorD = 1'b1; MemRead = 1'b1; end
      S_MEMWR:   begin IorD = 1'b1; MemWrite = 1'b1; end
      S_MEMWB:   begin MemtoReg = 1'b1; RegWrite = 1'b1; end
      S_EXEC:    begin ALUSrcA = 1'b1; ALUOp = ALUOP_FUNCT; end
      S_ALUWB:   begin RegDst = 1'b1; RegWrite = 1'b1; end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUOp    = ALUOP_SUB;
        PCSource = PCSRC_ALUOUT;
        Branch   = (opcode == OP_BEQ);
        BranchNe = (opcode == OP_BNE);
      end
`ifdef MULTICYCLE_JUMP_EN
      S_JUMP:    begin PCWrite = 1'b1; PCSource = PCSRC_JUMP; end
`endif
      S_ADDI_EX: begin ALUSrcA = 1'b1; ALUSrcB = SRCB_IMM; end
      S_ADDI_WB: RegWrite = 1'b1;
      S_TRAP:    begin exc_valid = 1'b1; exc_cause = cause_q; end
      default: ;
    endcase
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter CNT_W, default 32: width of retired-instruction counter.
REQ-002 Parameter MEM_TIMEOUT, default 16: max wait cycles for mem_ready; legal range >= 2.
REQ-003 Single clock, synchronous active-high reset: clk and rst; all state updates on clk rising edge.
REQ-004 clk  in  1  system clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 opcode  in  6  instruction opcode from IR, valid in DECODE.
REQ-007 mem_ready  in  1  memory completes current access this cycle.
REQ-008 PCWrite  out  1  unconditional PC write.
REQ-009 Branch  out  1  PC write if ALU zero (beq).
REQ-010 BranchNe  out  1  PC write if ALU not zero (bne).
REQ-011 IorD  out  1  0 = PC address, 1 = ALUOut address.
REQ-012 MemRead  out  1  memory read request.
REQ-013 MemWrite  out  1  memory write request.
REQ-014 MemtoReg  out  1  write-back from MDR.
REQ-015 IRWrite  out  1  load IR.
REQ-016 RegDst  out  1  1 = rd, 0 = rt.
REQ-017 RegWrite  out  1  register file write.
REQ-018 ALUSrcA  out  1  0 = PC, 1 = A.
REQ-019 ALUSrcB  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 shifted imm.
REQ-020 ALUOp  out  2  00 add, 01 sub, 10 funct-decoded.
REQ-021 PCSource  out  2  00 ALU, 01 ALUOut, 10 jump target.
REQ-022 exc_valid  out  1  one-cycle exception pulse.
REQ-023 exc_cause  out  2  01 illegal opcode, 10 memory timeout; 00 when exc_valid=0.
REQ-024 instr_count  out  CNT_W  retired-instruction count.

Function
REQ-025 States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, JUMP, ADDI_EX, ADDI_WB, TRAP. Outputs Moore-decoded from state, except FETCH IRWrite/PCWrite gated by mem_ready. Unlisted outputs 0.
REQ-026 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite=PCWrite=mem_ready; next DECODE on mem_ready, else hold.
REQ-027 DECODE: ALUSrcB=11, ALUOp=00; next: 000000->EXEC, 100011/101011->MEMADR, 000100/000101->BRANCH, 001000->ADDI_EX, 000010->JUMP (JUMP_EN only), else TRAP cause 01.
REQ-028 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; next MEMRD if lw, MEMWR if sw; opcode stays stable until instruction retires.
REQ-029 MEMRD: IorD=1, MemRead=1, hold until mem_ready -> MEMWB. MEMWR: IorD=1, MemWrite=1, hold until mem_ready -> FETCH.
REQ-030 MEMWB: MemtoReg=1, RegWrite=1, RegDst=0 -> FETCH. EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> ALUWB: RegDst=1, RegWrite=1 -> FETCH.
REQ-031 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01, Branch=1 (beq) or BranchNe=1 (bne) -> FETCH.
REQ-032 ADDI_EX: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> ADDI_WB: RegWrite=1, RegDst=0 -> FETCH. JUMP: PCWrite=1, PCSource=10 -> FETCH.
REQ-033 Wait counter cleared on entry to FETCH/MEMRD/MEMWR; increments each cycle without mem_ready; reaching MEM_TIMEOUT-1 without mem_ready -> TRAP cause 10; mem_ready on that same cycle wins (normal progress).
REQ-034 TRAP: exc_valid=1 with latched cause for exactly one cycle -> FETCH; no write strobes asserted.
REQ-035 instr_count +1 on leaving MEMWB, MEMWR (with mem_ready), ALUWB, BRANCH, JUMP, ADDI_WB; TRAP does not count; wraps modulo 2^CNT_W.
REQ-036 Latency: R-type 4, beq/bne 3, addi 4, j 3, sw 4, lw 5 cycles with zero memory wait.

Reset
REQ-037 rst=1 on a clock edge -> state FETCH, wait counter 0, instr_count 0, latched cause 00, regardless of current state (incl. mid-access or TRAP).
REQ-038 During and first cycle after reset, all outputs are FETCH-state values (MemRead=1, ALUSrcB=01, others 0); exc_valid=0.

Configuration
REQ-039 Macro MULTICYCLE_JUMP_EN defined: opcode 000010 -> JUMP. Undefined: JUMP state absent, 000010 -> TRAP cause 01, PCSource never 10.

Structure
REQ-040 Package mips_ctrl_pkg holds state enum, opcode localparams, ALUOp/ALUSrcB/PCSource/exc_cause encodings.
REQ-041 One sub-module ctrl_wait_timer (clear, tick, ready in; expired out) parametrised by MEM_TIMEOUT.

Verification
REQ-042 R-type 000000, mem_ready=1 -> FETCH,DECODE,EXEC,ALUWB; RegWrite=RegDst=1 in cycle 4; instr_count 0->1.
REQ-043 lw 100011, mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles, MemRead=IorD=1 throughout, then MEMWB with MemtoReg=1.
REQ-044 sw with MEM_TIMEOUT=4, mem_ready never -> TRAP after 4 MEMWR cycles, exc_valid=1, exc_cause=10, instr_count unchanged.
REQ-045 opcode 111111 in DECODE -> TRAP, exc_cause=01 one cycle, then FETCH; 000010 same when MULTICYCLE_JUMP_EN undefined, JUMP with PCSource=10 when defined.
REQ-046 bne 000101 -> BRANCH with BranchNe=1, Branch=0, ALUOp=01; rst asserted in MEMRD -> FETCH next cycle, instr_count=0.
REQ-047 CNT_W=4, 16 retired instructions -> instr_count wraps 15->0.
